// File: rtl/tx_payload_fifo.sv
// tx_payload_fifo
// First-word-fall-through payload buffer feeding the Interlaken TX framer.
// A burst toward the framer starts only once a complete packet, or a
// threshold number of words, is buffered. This keeps idle insertion inside
// a packet to a minimum. An empty slot taken by the framer while streaming
// sets a sticky underrun flag.
module tx_payload_fifo #(
  parameter int DEPTH           = 32,
  parameter int START_THRESHOLD = 8,
  parameter int AFULL_THRESHOLD = 28
) (
  input  logic                       USER_CLK,
  input  logic                       SYSTEM_RESET_N,
  input  logic [63:0]                WR_DATA,
  input  logic                       WR_EOP,
  input  logic                       WR_VALID,
  output logic                       WR_READY,
  output logic [63:0]                TX_DATA,
  output logic                       TX_DATA_TO_SEND,
  input  logic                       TX_DATA_IN_READY,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       ALMOST_FULL,
  output logic                       UNDERRUN,
  input  logic                       CLEAR_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_START = LW'(START_THRESHOLD);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_THRESHOLD);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Storage entries are {eop, data}.
  logic [64:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [LW-1:0]  level_r;
  logic [LW-1:0]  level_next_s;
  logic [LW-1:0]  pkt_cnt_r;
  logic [LW-1:0]  pkt_cnt_next_s;
  logic           wr_ready_r;
  logic           afull_r;
  logic           underrun_r;
  logic           to_send_s;
  state_t         state_r;
  state_t         state_next_s;
  logic [64:0]    head_s;
  logic           push_s;
  logic           pop_s;
  logic           push_eop_s;
  logic           pop_eop_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign push_s     = WR_VALID & wr_ready_r;
  assign pop_s      = TX_DATA_IN_READY & to_send_s;
  assign push_eop_s = push_s & WR_EOP;
  assign pop_eop_s  = pop_s & head_s[64];

  assign TX_DATA         = head_s[63:0];
  assign TX_DATA_TO_SEND = to_send_s;
  assign WR_READY        = wr_ready_r;
  assign LEVEL           = level_r;
  assign ALMOST_FULL     = afull_r;
  assign UNDERRUN        = underrun_r;

  // Write the pushed word into the entry addressed by the write pointer.
  always_ff @(posedge USER_CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {WR_EOP, WR_DATA};
    end
  end

  // Next stored-word count; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_next_s = level_r;
    if (push_s && !pop_s) begin
      level_next_s = level_r + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_next_s = level_r - LVL_ONE;
    end else begin
      level_next_s = level_r;
    end
  end

  // Next count of EOP words held in storage.
  always_comb begin
    pkt_cnt_next_s = pkt_cnt_r;
    if (push_eop_s && !pop_eop_s) begin
      pkt_cnt_next_s = pkt_cnt_r + LVL_ONE;
    end else if (!push_eop_s && pop_eop_s) begin
      pkt_cnt_next_s = pkt_cnt_r - LVL_ONE;
    end else begin
      pkt_cnt_next_s = pkt_cnt_r;
    end
  end

  // Pointers, occupancy, packet count and registered status flags.
  // WR_READY looks at the next level, so it stays low through a pop at full.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= LVL_ZERO;
      pkt_cnt_r  <= LVL_ZERO;
      wr_ready_r <= 1'b0;
      afull_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r    <= level_next_s;
      pkt_cnt_r  <= pkt_cnt_next_s;
      wr_ready_r <= (level_next_s != LVL_DEPTH);
      afull_r    <= (level_next_s >= LVL_AFULL);
    end
  end

  // Sticky underrun: set when the framer takes a slot while streaming empty.
  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      underrun_r <= 1'b0;
    end else if ((state_r == ST_STREAM) && (level_r == LVL_ZERO) && TX_DATA_IN_READY) begin
      underrun_r <= 1'b1;
    end else if (CLEAR_ERR) begin
      underrun_r <= 1'b0;
    end
  end

  // Burst control state register.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Start a burst on a full packet or enough words; end it after the EOP leaves.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((pkt_cnt_r != LVL_ZERO) || (level_r >= LVL_START)) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (pop_eop_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Offer the head word only while streaming and something is stored.
  always_comb begin
    to_send_s = 1'b0;
    case (state_r)
      ST_IDLE:   to_send_s = 1'b0;
      ST_STREAM: to_send_s = (level_r != LVL_ZERO);
      default:   to_send_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_tx_payload_fifo.sv
// tb_tx_payload_fifo
// Directed bench for tx_payload_fifo with a word-order scoreboard.
module tb_tx_payload_fifo;

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET_N;
  logic [63:0] WR_DATA;
  logic        WR_EOP;
  logic        WR_VALID;
  logic        WR_READY;
  logic [63:0] TX_DATA;
  logic        TX_DATA_TO_SEND;
  logic        TX_DATA_IN_READY;
  logic [5:0]  LEVEL;
  logic        ALMOST_FULL;
  logic        UNDERRUN;
  logic        CLEAR_ERR;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [63:0] sb_q[$];

  tx_payload_fifo #(
    .DEPTH(32),
    .START_THRESHOLD(8),
    .AFULL_THRESHOLD(28)
  ) dut (
    .USER_CLK(USER_CLK),
    .SYSTEM_RESET_N(SYSTEM_RESET_N),
    .WR_DATA(WR_DATA),
    .WR_EOP(WR_EOP),
    .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .TX_DATA(TX_DATA),
    .TX_DATA_TO_SEND(TX_DATA_TO_SEND),
    .TX_DATA_IN_READY(TX_DATA_IN_READY),
    .LEVEL(LEVEL),
    .ALMOST_FULL(ALMOST_FULL),
    .UNDERRUN(UNDERRUN),
    .CLEAR_ERR(CLEAR_ERR)
  );

  always #5 USER_CLK = ~USER_CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the scoreboard for the
  // transfers that the coming rising edge performs, return 1 after that edge.
  task automatic tick();
    @(negedge USER_CLK);
    check("level", 64'(LEVEL), 64'(sb_q.size()));
    if (TX_DATA_IN_READY && TX_DATA_TO_SEND) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL pop_empty observed=%0h expected=none", TX_DATA);
      end
      if (sb_q.size() != 0) begin
        check("tx_data", TX_DATA, sb_q.pop_front());
        pops++;
      end
    end
    if (WR_VALID && WR_READY) begin
      sb_q.push_back(WR_DATA);
    end
    @(posedge USER_CLK);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d, input logic eop);
    WR_VALID = 1'b1;
    WR_DATA  = d;
    WR_EOP   = eop;
    tick();
    WR_VALID = 1'b0;
    WR_EOP   = 1'b0;
  endtask

  task automatic wait_to_send(input string tag);
    int n = 0;
    while (TX_DATA_TO_SEND !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(TX_DATA_TO_SEND), 64'd1);
  endtask

  task automatic wait_pops(input string tag, input int target);
    int n = 0;
    while (pops < target && n < 40) begin
      tick();
      n++;
    end
    check(tag, 64'(pops), 64'(target));
  endtask

  task automatic apply_reset();
    WR_VALID         = 1'b0;
    WR_EOP           = 1'b0;
    TX_DATA_IN_READY = 1'b0;
    CLEAR_ERR        = 1'b0;
    SYSTEM_RESET_N   = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge USER_CLK);
    #1;
    SYSTEM_RESET_N = 1'b1;
    check("rst_wr_ready_low", 64'(WR_READY), 64'd0);
    tick();
    check("rst_wr_ready_high", 64'(WR_READY), 64'd1);
  endtask

  initial begin
    SYSTEM_RESET_N   = 1'b0;
    WR_DATA          = 64'd0;
    WR_EOP           = 1'b0;
    WR_VALID         = 1'b0;
    TX_DATA_IN_READY = 1'b0;
    CLEAR_ERR        = 1'b0;

    // 1: reset state and WR_READY rising one edge after release
    repeat (3) @(posedge USER_CLK);
    #1;
    check("r_wr_ready", 64'(WR_READY), 64'd0);
    check("r_level", 64'(LEVEL), 64'd0);
    check("r_to_send", 64'(TX_DATA_TO_SEND), 64'd0);
    check("r_underrun", 64'(UNDERRUN), 64'd0);
    check("r_afull", 64'(ALMOST_FULL), 64'd0);
    SYSTEM_RESET_N = 1'b1;
    check("r_wr_ready_pre_edge", 64'(WR_READY), 64'd0);
    tick();
    check("r_wr_ready_post_edge", 64'(WR_READY), 64'd1);

    // 2: three-word packet with the framer always ready
    TX_DATA_IN_READY = 1'b1;
    pops = 0;
    push_word(64'h1111_0000_0000_0001, 1'b0);
    push_word(64'h1111_0000_0000_0002, 1'b0);
    push_word(64'h1111_0000_0000_0003, 1'b1);
    check("p2_idle_at_pkt", 64'(TX_DATA_TO_SEND), 64'd0);
    tick();
    check("p2_to_send_rise", 64'(TX_DATA_TO_SEND), 64'd1);
    wait_pops("p2_pops", 3);
    check("p2_to_send_after_eop", 64'(TX_DATA_TO_SEND), 64'd0);
    check("p2_level_end", 64'(LEVEL), 64'd0);

    // 3: threshold start without EOP, then eight single-cycle pops
    TX_DATA_IN_READY = 1'b0;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      push_word({32'h3333_0000, $urandom}, 1'b0);
      if (i == 6) begin
        check("p3_no_send_at_7", 64'(TX_DATA_TO_SEND), 64'd0);
      end
    end
    wait_to_send("p3_send_at_8");
    check("p3_level_at_send", 64'(LEVEL), 64'd8);
    for (int i = 0; i < 8; i++) begin
      TX_DATA_IN_READY = 1'b1;
      tick();
      TX_DATA_IN_READY = 1'b0;
      tick();
    end
    check("p3_pops", 64'(pops), 64'd8);
    check("p3_level_end", 64'(LEVEL), 64'd0);

    // 4: fill to full, then a push attempt during a pop at full
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      push_word({32'h4444_0000, 32'(i)}, 1'b0);
      check("p4_afull", 64'(ALMOST_FULL), 64'((i + 1) >= 28));
      check("p4_wr_ready", 64'(WR_READY), 64'((i + 1) != 32));
    end
    check("p4_level_full", 64'(LEVEL), 64'd32);
    check("p4_to_send_full", 64'(TX_DATA_TO_SEND), 64'd1);
    pops = 0;
    WR_VALID         = 1'b1;
    WR_DATA          = 64'hDEAD_BEEF_DEAD_BEEF;
    TX_DATA_IN_READY = 1'b1;
    tick();
    WR_VALID         = 1'b0;
    TX_DATA_IN_READY = 1'b0;
    check("p4_level_31", 64'(LEVEL), 64'd31);
    check("p4_wr_ready_reopen", 64'(WR_READY), 64'd1);
    check("p4_one_pop", 64'(pops), 64'd1);

    // 5: drain to empty while the framer stays ready; sticky underrun
    apply_reset();
    TX_DATA_IN_READY = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      push_word({32'h5555_0000, $urandom}, 1'b0);
    end
    wait_to_send("p5_send");
    wait_pops("p5_pops", 8);
    check("p5_no_underrun_yet", 64'(UNDERRUN), 64'd0);
    tick();
    check("p5_underrun_set", 64'(UNDERRUN), 64'd1);
    TX_DATA_IN_READY = 1'b0;
    CLEAR_ERR = 1'b1;
    tick();
    check("p5_clear", 64'(UNDERRUN), 64'd0);
    TX_DATA_IN_READY = 1'b1;
    tick();
    check("p5_set_wins", 64'(UNDERRUN), 64'd1);
    TX_DATA_IN_READY = 1'b0;
    tick();
    CLEAR_ERR = 1'b0;
    check("p5_clear_again", 64'(UNDERRUN), 64'd0);

    // 6: asynchronous reset in the middle of a streaming packet
    apply_reset();
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      push_word({32'h6666_0000, 32'(i)}, 1'b0);
    end
    wait_to_send("p6_send");
    TX_DATA_IN_READY = 1'b1;
    wait_pops("p6_pops", 3);
    TX_DATA_IN_READY = 1'b0;
    check("p6_level_5", 64'(LEVEL), 64'd5);
    check("p6_to_send_pre", 64'(TX_DATA_TO_SEND), 64'd1);
    #2;
    SYSTEM_RESET_N = 1'b0;
    #1;
    check("p6_async_level", 64'(LEVEL), 64'd0);
    check("p6_async_to_send", 64'(TX_DATA_TO_SEND), 64'd0);
    check("p6_async_wr_ready", 64'(WR_READY), 64'd0);
    apply_reset();
    TX_DATA_IN_READY = 1'b1;
    pops = 0;
    push_word(64'h7777_0000_0000_00A1, 1'b0);
    push_word(64'h7777_0000_0000_00A2, 1'b1);
    wait_to_send("p6_next_send");
    wait_pops("p6_next_pops", 2);
    check("p6_next_to_send_end", 64'(TX_DATA_TO_SEND), 64'd0);
    check("p6_next_level", 64'(LEVEL), 64'd0);
    check("p6_next_underrun", 64'(UNDERRUN), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
